// File: rtl/evatop_discharge_seq.sv
// EVA top emulation-supply discharge sequencer.
// Debounced request drives EMVDD, then EMEVDD discharge windows.
module evatop_discharge_seq #(
    parameter int DEB_CYC = 16,
    parameter int DIS_CYC = 1024,
    parameter int GAP_CYC = 64,
    parameter int CNT_W   = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PSEUDOON31,
    input  logic       CLK60MHZLOCK,
    output logic       DISEMVDD_EN,
    output logic       DISEMEVDD_EN,
    output logic       DISBUSY,
    output logic       DISDONE,
    output logic       DISABORT,
    output logic [2:0] DISSTATE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEB      = 3'd1,
        DIS_VDD  = 3'd2,
        GAP      = 3'd3,
        DIS_EVDD = 3'd4,
        HOLD     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DIS_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_q;
    logic             req_s;
    logic             done_q;
    logic             done_d;
    logic             abort_q;
    logic             abort_d;
    logic             ok;

    assign ok = req_s & CLK60MHZLOCK;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ok) state_d = DEB;
            end
            DEB: begin
                if (!ok) state_d = IDLE;
                else if (cnt_q == DEB_LAST) state_d = DIS_VDD;
            end
            DIS_VDD: begin
                if (!ok) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == DIS_LAST) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (!ok) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = DIS_EVDD;
                end
            end
            DIS_EVDD: begin
                // abort wins over a coincident terminal count
                if (!ok) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == DIS_LAST) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                end
            end
            HOLD: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q    <= 1'b0;
            req_s   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            s1_q    <= PSEUDOON31;
            req_s   <= s1_q;
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_ONE;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign DISEMVDD_EN  = (state_q == DIS_VDD);
    assign DISEMEVDD_EN = (state_q == DIS_EVDD);
    assign DISBUSY      = (state_q == DEB) || (state_q == DIS_VDD) ||
                          (state_q == GAP) || (state_q == DIS_EVDD);
    assign DISDONE      = done_q;
    assign DISABORT     = abort_q;
    // illegal codes read back as 0 for the single cycle before recovery
    assign DISSTATE     = (state_q <= HOLD) ? state_q : 3'd0;

endmodule

// File: tb/tb_evatop_discharge_seq.sv
// Directed scoreboard bench for evatop_discharge_seq.
// Expected per-cycle output vectors are queued, then popped each edge.
module tb_evatop_discharge_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pin;
    logic       lock;
    logic       en_vdd;
    logic       en_evdd;
    logic       busy;
    logic       done;
    logic       abort;
    logic [2:0] st;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    evatop_discharge_seq #(
        .DEB_CYC(4),
        .DIS_CYC(8),
        .GAP_CYC(3),
        .CNT_W(4)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .PSEUDOON31(pin),
        .CLK60MHZLOCK(lock),
        .DISEMVDD_EN(en_vdd),
        .DISEMEVDD_EN(en_evdd),
        .DISBUSY(busy),
        .DISDONE(done),
        .DISABORT(abort),
        .DISSTATE(st)
    );

    function automatic logic [7:0] mk(logic [2:0] s, logic dn, logic ab);
        logic b;
        b = (s >= 3'd1) && (s <= 3'd4);
        return {s, s == 3'd2, s == 3'd4, b, dn, ab};
    endfunction

    task automatic push(string tag, logic [2:0] s, int n,
                        logic dn = 1'b0, logic ab = 1'b0);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.v   = mk(s, dn, ab);
            sb.push_back(e);
        end
    endtask

    task automatic push_seq(string tag);
        push({tag, "_deb"}, 3'd1, 4);
        push({tag, "_vdd"}, 3'd2, 8);
        push({tag, "_gap"}, 3'd3, 3);
        push({tag, "_evdd"}, 3'd4, 8);
        push({tag, "_done"}, 3'd5, 1, 1'b1, 1'b0);
    endtask

    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            exp_t       e;
            logic [7:0] obs;
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
            end else begin
                e.tag = "sb_underflow";
                e.v   = 8'hxx;
            end
            obs = {st, en_vdd, en_evdd, busy, done, abort};
            total++;
            assert (obs === e.v) passed++;
            else begin
                failed++;
                $error("FAIL %s obs=%b exp=%b", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        pin  = 1'b1;
        lock = 1'b1;
        push("reset", 3'd0, 3);
        cyc(3);

        rst = 1'b0;
        push("rel_sync", 3'd0, 2);
        push_seq("full1");
        push("hold", 3'd5, 20);
        cyc(2 + 24 + 20);

        pin = 1'b0;
        push("rearm_hold", 3'd5, 2);
        push("rearm_idle", 3'd0, 3);
        cyc(5);

        pin = 1'b1;
        push("seq2_sync", 3'd0, 2);
        push_seq("full2");
        cyc(2 + 24);
        pin = 1'b0;
        push("seq2_hold", 3'd5, 2);
        push("seq2_idle", 3'd0, 2);
        cyc(4);

        pin = 1'b1;
        push("glitch_sync", 3'd0, 2);
        push("glitch_deb", 3'd1, 1);
        cyc(3);
        pin = 1'b0;
        push("glitch_deb2", 3'd1, 2);
        push("glitch_idle", 3'd0, 2);
        cyc(4);

        pin = 1'b1;
        push("ab_sync", 3'd0, 2);
        push("ab_deb", 3'd1, 4);
        push("ab_vdd", 3'd2, 8);
        push("ab_gap", 3'd3, 3);
        push("ab_evdd", 3'd4, 4);
        cyc(21);
        pin = 1'b0;
        push("ab_evdd_tail", 3'd4, 2);
        push("ab_pulse", 3'd0, 1, 1'b0, 1'b1);
        push("ab_idle", 3'd0, 2);
        cyc(5);

        pin = 1'b1;
        push("pri_sync", 3'd0, 2);
        push("pri_deb", 3'd1, 4);
        push("pri_vdd", 3'd2, 8);
        push("pri_gap", 3'd3, 3);
        push("pri_evdd", 3'd4, 6);
        cyc(23);
        pin = 1'b0;
        push("pri_evdd_tail", 3'd4, 2);
        push("pri_abort", 3'd0, 1, 1'b0, 1'b1);
        push("pri_idle", 3'd0, 2);
        cyc(5);

        pin = 1'b1;
        push("lk_sync", 3'd0, 2);
        push("lk_deb", 3'd1, 4);
        push("lk_vdd", 3'd2, 8);
        push("lk_gap", 3'd3, 1);
        cyc(15);
        lock = 1'b0;
        push("lk_abort", 3'd0, 1, 1'b0, 1'b1);
        push("lk_idle", 3'd0, 2);
        cyc(3);
        pin = 1'b0;
        push("lk_flush", 3'd0, 3);
        cyc(3);
        lock = 1'b1;
        push("lk_relock", 3'd0, 2);
        cyc(2);

        pin = 1'b1;
        push("rm_sync", 3'd0, 2);
        push("rm_deb", 3'd1, 4);
        push("rm_vdd", 3'd2, 5);
        cyc(11);
        rst = 1'b1;
        push("rm_reset", 3'd0, 2);
        cyc(2);
        pin = 1'b0;
        rst = 1'b0;
        push("rm_idle", 3'd0, 3);
        cyc(3);

        total++;
        assert (sb.size() === 0) passed++;
        else begin
            failed++;
            $error("FAIL sb_leftover obs=%0d exp=0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
